// File: rtl/sevseg_mux.sv
// Time-multiplexed hex seven-segment driver: N digits, per-digit DP, leading-zero
// blanking, PWM brightness and a frame-aligned double buffer for tear-free updates.
module sevseg_mux #(
    parameter int DIGITS         = 2,
    parameter int REFRESH_DIV    = 12000,
    parameter int BRIGHT_W       = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   DATA,
    input  logic [DIGITS-1:0]     DP,
    input  logic                  LOAD,
    input  logic                  BLANK_LZ,
    input  logic [BRIGHT_W-1:0]   BRIGHT,
    output logic [6:0]            SEG,
    output logic                  SEG_DP,
    output logic [DIGITS-1:0]     SEL,
    output logic                  PENDING,
    output logic                  FRAME
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [PRE_W-1:0]  LAST_PRE = PRE_W'(REFRESH_DIV - 1);
    localparam logic [6:0]        SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] SEL_OFF  = {DIGITS{SEL_ACTIVE_LOW}};

    logic [PRE_W-1:0]    prescaler;
    logic [IDX_W-1:0]    idx;
    logic [BRIGHT_W-1:0] pwm;
    logic [4*DIGITS-1:0] active_data;
    logic [DIGITS-1:0]   active_dp;
    logic [4*DIGITS-1:0] pend_data;
    logic [DIGITS-1:0]   pend_dp;

    logic                tick;
    logic                boundary;
    logic                en;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic [DIGITS-1:0]   sel_hot;
    logic                upper_zero;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign tick     = (prescaler == LAST_PRE);
    assign boundary = tick && (idx == LAST_IDX);
    assign en       = (&BRIGHT) || (pwm < BRIGHT);

    // Walk from the most significant digit down so a digit knows whether all above it are zero.
    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        sel_hot    = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (active_data[4*i +: 4] == 4'h0);
            if (IDX_W'(i) == idx) begin
                cur_nib    = active_data[4*i +: 4];
                cur_dp     = active_dp[i];
                cur_blank  = BLANK_LZ && (i != 0) && upper_zero;
                sel_hot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            prescaler   <= '0;
            idx         <= '0;
            pwm         <= '0;
            active_data <= '0;
            active_dp   <= '0;
            pend_data   <= '0;
            pend_dp     <= '0;
            PENDING     <= 1'b0;
            FRAME       <= 1'b0;
            SEG         <= SEG_OFF;
            SEG_DP      <= SEG_ACTIVE_LOW;
            SEL         <= SEL_OFF;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            pwm       <= tick ? '0 : pwm + 1'b1;
            if (tick) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            FRAME <= boundary;

            // A LOAD landing on the boundary goes straight to the active buffer.
            if (boundary) begin
                if (LOAD) begin
                    active_data <= DATA;
                    active_dp   <= DP;
                end else if (PENDING) begin
                    active_data <= pend_data;
                    active_dp   <= pend_dp;
                end
                PENDING <= 1'b0;
            end else if (LOAD) begin
                pend_data <= DATA;
                pend_dp   <= DP;
                PENDING   <= 1'b1;
            end

            SEL    <= en ? (sel_hot ^ SEL_OFF) : SEL_OFF;
            SEG    <= (en && !cur_blank) ? (hex_to_seg(cur_nib) ^ SEG_OFF) : SEG_OFF;
            SEG_DP <= en ? (cur_dp ^ SEG_ACTIVE_LOW) : SEG_ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_sevseg_mux.sv
// Bench for sevseg_mux: two instances (active-high and active-low pins) against a
// cycle-count based display model; expected pin values flow through a queue to a monitor.
module tb_sevseg_mux;

    localparam int D  = 4;
    localparam int RD = 16;
    localparam int BW = 4;
    localparam int FRAME_LEN = D * RD;

    logic          clk = 1'b0;
    logic          rst;
    logic [4*D-1:0] data;
    logic [D-1:0]  dp;
    logic          load;
    logic          blank_lz;
    logic [BW-1:0] bright;

    logic [6:0]    seg_a, seg_b;
    logic          seg_dp_a, seg_dp_b;
    logic [D-1:0]  sel_a, sel_b;
    logic          pending_a, pending_b;
    logic          frame_a, frame_b;

    int errors = 0;
    int checks = 0;

    // {seg, dp, sel, pending, frame}
    localparam int W = 7 + 1 + D + 2;
    logic [W-1:0] exp_q[$];

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state: cycle count since reset plus the two display buffers.
    int             m_t = 0;
    logic [4*D-1:0] m_act = '0;
    logic [4*D-1:0] m_pend = '0;
    logic [D-1:0]   m_act_dp = '0;
    logic [D-1:0]   m_pend_dp = '0;
    logic           m_pending = 1'b0;

    always #5 clk = ~clk;

    sevseg_mux #(
        .DIGITS(D), .REFRESH_DIV(RD), .BRIGHT_W(BW),
        .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b0)
    ) dut_a (
        .CLK(clk), .RST(rst), .DATA(data), .DP(dp), .LOAD(load), .BLANK_LZ(blank_lz),
        .BRIGHT(bright), .SEG(seg_a), .SEG_DP(seg_dp_a), .SEL(sel_a),
        .PENDING(pending_a), .FRAME(frame_a)
    );

    sevseg_mux #(
        .DIGITS(D), .REFRESH_DIV(RD), .BRIGHT_W(BW),
        .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
    ) dut_b (
        .CLK(clk), .RST(rst), .DATA(data), .DP(dp), .LOAD(load), .BLANK_LZ(blank_lz),
        .BRIGHT(bright), .SEG(seg_b), .SEG_DP(seg_dp_b), .SEL(sel_b),
        .PENDING(pending_b), .FRAME(frame_b)
    );

    // Reference model: predicts the pins that appear after each rising edge.
    initial begin
        int pos, idx, pwm, nib;
        bit en, blank, bnd;
        logic [6:0] e_seg;
        logic e_dp;
        logic [D-1:0] e_sel;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_t = 0; m_act = '0; m_pend = '0; m_act_dp = '0; m_pend_dp = '0;
                m_pending = 1'b0;
                exp_q.push_back('0);
            end else begin
                pos   = m_t % RD;
                idx   = (m_t / RD) % D;
                pwm   = pos % (1 << BW);
                en    = (bright == 4'hF) || (pwm < int'(bright));
                nib   = int'((m_act >> (4 * idx)) & 16'h000F);
                blank = blank_lz && (idx > 0) && ((m_act >> (4 * idx)) == 0);
                e_seg = (en && !blank) ? seg_tab[nib] : 7'h00;
                e_dp  = en ? m_act_dp[idx] : 1'b0;
                e_sel = en ? D'(1 << idx) : '0;
                bnd   = (pos == RD - 1) && (idx == D - 1);
                if (bnd) begin
                    if (load) begin
                        m_act = data; m_act_dp = dp;
                    end else if (m_pending) begin
                        m_act = m_pend; m_act_dp = m_pend_dp;
                    end
                    m_pending = 1'b0;
                end else if (load) begin
                    m_pend = data; m_pend_dp = dp; m_pending = 1'b1;
                end
                exp_q.push_back({e_seg, e_dp, e_sel, m_pending, bnd});
                m_t++;
            end
        end
    end

    // Monitor: one expected word per edge, checked on the falling edge for both instances.
    initial begin
        logic [W-1:0] e, got;
        @(posedge clk);
        forever begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL queue_empty t=%0t got=nothing required=one expected entry", $time);
            end else begin
                e   = exp_q.pop_front();
                got = {seg_a, seg_dp_a, sel_a, pending_a, frame_a};
                if (got !== e)
                    $display("FAIL pins_high t=%0t got={seg,dp,sel,pend,frame}=%h required=%h", $time, got, e);
                if (got !== e) errors++;
                checks++;
                e   = e ^ {7'h7F, 1'b1, {D{1'b1}}, 2'b00};
                got = {seg_b, seg_dp_b, sel_b, pending_b, frame_b};
                if (got !== e) begin
                    errors++;
                    $display("FAIL pins_low t=%0t got={seg,dp,sel,pend,frame}=%h required=%h", $time, got, e);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge; LOAD is high for exactly the next rising edge.
    task automatic do_load(input logic [4*D-1:0] d, input logic [D-1:0] p);
        data = d;
        dp   = p;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_slot_pos(input int frame_pos);
        int guard = 0;
        while ((m_t % FRAME_LEN) != frame_pos && guard < 4 * FRAME_LEN) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 4 * FRAME_LEN) begin
            errors++;
            $display("FAIL wait_timeout pos=%0d got=%0d cycles required=<%0d", frame_pos, guard, 4 * FRAME_LEN);
        end
    endtask

    initial begin
        rst = 1'b1; data = '0; dp = '0; load = 1'b0; blank_lz = 1'b0; bright = 4'hF;
        idle(3);
        rst = 1'b0;

        // Plain scan of 0x..A5 at full brightness.
        do_load(16'h00A5, 4'b0000);
        idle(2 * FRAME_LEN);

        // Mid-frame load stays pending until the boundary.
        wait_slot_pos(20);
        do_load(16'h0012, 4'b0001);
        idle(FRAME_LEN);

        // Load exactly on the boundary cycle bypasses the pending buffer.
        wait_slot_pos(FRAME_LEN - 1);
        do_load(16'h3456, 4'b0101);
        idle(FRAME_LEN + 5);

        // Leading-zero blanking on and off.
        blank_lz = 1'b1;
        do_load(16'h0030, 4'b1000);
        idle(2 * FRAME_LEN);
        blank_lz = 1'b0;
        idle(FRAME_LEN);
        blank_lz = 1'b1;
        do_load(16'h0000, 4'b0000);
        idle(2 * FRAME_LEN);

        // Brightness levels.
        do_load(16'h8421, 4'b1111);
        bright = 4'h4;
        idle(2 * FRAME_LEN);
        bright = 4'h0;
        idle(FRAME_LEN);
        bright = 4'hF;
        idle(FRAME_LEN);

        // Reset mid-frame with a load pending.
        wait_slot_pos(30);
        do_load(16'hBEEF, 4'b0011);
        idle(2);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2 * FRAME_LEN + 10);

        // Randomized traffic.
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < D; i++)
                data[4*i +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
            dp   = D'($urandom_range(0, (1 << D) - 1));
            load = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 49) == 0)
                bright = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0)
                blank_lz = ~blank_lz;
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                idle($urandom_range(1, 3));
                rst = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sevseg_mux.md
Name: sevseg_mux

Overview:
Parametrised time-multiplexed hex seven-segment driver for N common-cathode/anode digits on a Pmod header. It generalises the fixed two-digit driver with:
- configurable digit count and refresh rate
- per-digit decimal points
- leading-zero blanking
- PWM brightness
- tear-free double-buffered loading

It sits between a host register source (e.g. the UART command block) and the Pmod pins.

Parameters:
DIGITS, 2, number of multiplexed digits (1..8)
REFRESH_DIV, 12000, CLK cycles per digit slot (>=2^BRIGHT_W)
BRIGHT_W, 4, brightness control width
SEG_ACTIVE_LOW, 0, 1 = segment/DP outputs active-low
SEL_ACTIVE_LOW, 0, 1 = digit-select outputs active-low

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
DATA  in  4*DIGITS  hex nibbles, digit i = DATA[4i+3:4i], digit 0 least significant
DP  in  DIGITS  decimal point per digit
LOAD  in  1  single-cycle strobe: capture DATA/DP
BLANK_LZ  in  1  enable leading-zero blanking
BRIGHT  in  BRIGHT_W  duty control, 0 = dark, all-ones = full on
SEG  out  7  segments {g,f,e,d,c,b,a}, SEG[0]=a
SEG_DP  out  1  decimal point segment
SEL  out  DIGITS  one-hot digit select
PENDING  out  1  loaded value waiting for frame boundary
FRAME  out  1  one-cycle pulse at each frame start

Behaviour:
- Clock and reset: one clock CLK; RST is synchronous, active-high, and is honoured on any cycle, including mid-frame or with PENDING=1.
- Reset values:
  - prescaler=0, digit index=0, pwm counter=0
  - active and pending buffers=0, PENDING=0, FRAME=0
  - SEL and SEG/SEG_DP all inactive, per polarity parameters
- Prescaler: counts 0..REFRESH_DIV-1. tick = (prescaler==REFRESH_DIV-1).
  - On tick: index advances, DIGITS-1 wraps to 0.
  - Frame boundary = tick with index==DIGITS-1.
  - FRAME asserts for exactly the cycle after the boundary.
- PWM: BRIGHT_W-bit counter.
  - Clears on tick; otherwise increments and wraps.
  - Digit enable en = (BRIGHT==all-ones) || (pwm < BRIGHT).
- Double buffer:
  - LOAD copies DATA/DP into pending and sets PENDING=1.
  - At a frame boundary with PENDING=1: active <= pending, PENDING <= 0.
  - LOAD on the boundary cycle bypasses: active <= DATA/DP directly, PENDING=0.
  - LOAD while PENDING=1 (not on a boundary) overwrites pending; last write wins.
  - Display content never changes mid-frame.
- Decode: hex to segments, as abcdefg hex with a = LSB:
  0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Leading-zero blanking: with BLANK_LZ=1, digit i>0 is blanked when nibbles i..DIGITS-1 of the active buffer are all zero.
  - Digit 0 is never blanked.
  - A blanked digit drives SEG off but still shows its DP bit.
- Output stage: registered, 1-cycle latency from index/pwm/active state.
  - SEL = one-hot(index) when en, else all inactive.
  - SEG/SEG_DP are forced inactive when en=0.
  - Polarity inversion is applied at the output register.
- Inputs: BRIGHT and BLANK_LZ are sampled live every cycle and are not buffered.

Test Plan:
- Reset: RST high 3 cycles mid-frame with PENDING=1 -> next cycle SEL=0, SEG=0, PENDING=0, index restarts at 0; after release, first FRAME pulse follows DIGITS*REFRESH_DIV cycles later.
- Scan/decode: DIGITS=2, REFRESH_DIV=16, BRIGHT=F, LOAD DATA=8'hA5 -> after boundary, SEL=01 with SEG=6D for 16 cycles, then SEL=10 with SEG=77 for 16 cycles, then repeat.
- Tear-free load: LOAD 8'h12 mid-frame -> PENDING=1, SEG values unchanged until boundary; LOAD on exact boundary cycle -> applied that frame, PENDING stays 0.
- Blanking: DIGITS=4, DATA=16'h0030, DP=4'b1000, BLANK_LZ=1 -> digits 3,2 SEG=00 (digit 3 SEG_DP=1), digit 1 SEG=4F, digit 0 SEG=3F; BLANK_LZ=0 -> digits 3,2 show 3F.
- Brightness: REFRESH_DIV=32, BRIGHT=4 -> SEL active exactly 4 of every 16 cycles per slot; BRIGHT=0 -> SEL never active; BRIGHT=F -> active all 32 cycles.
- Polarity: SEG_ACTIVE_LOW=1, SEL_ACTIVE_LOW=1, digit value 1 -> SEG=79, SEL bit for the active digit =0, others 1; in reset all SEG/SEL pins =1.
